// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_alu_mul_if.sv
// Operand/result handshake bundle between the register-read stage and the ALU.
interface seq_alu_mul_if #(parameter int unsigned WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow
    );
endinterface

// File: rtl/seq_alu_addsub.sv
// Combinational add/subtract shared by ADD, SUB, BEQ, SLT and SLTU.
module seq_alu_addsub #(parameter int unsigned WIDTH = 32) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH:0]   w_full;

    always_comb begin
        w_bp       = i_sub ? ~i_b : i_b;
        w_full     = {1'b0, i_a} + {1'b0, w_bp} + {{WIDTH{1'b0}}, i_sub};
        o_sum      = w_full[WIDTH-1:0];
        o_carry    = w_full[WIDTH];
        o_overflow = (i_a[WIDTH-1] == w_bp[WIDTH-1]) & (w_full[WIDTH-1] != i_a[WIDTH-1]);
    end
endmodule

// File: rtl/seq_alu_mul.sv
// Registered ALU with valid/ready handshakes and an iterative shift-and-add multiply.
module seq_alu_mul
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_alu_mul_if.slave  bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_vout;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_accept;
    logic               w_mul_last;

    seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (bus.a),
        .i_b        (bus.b),
        .i_sub      (bus.op[2]),
        .o_sum      (w_sum),
        .o_carry    (w_cout),
        .o_overflow (w_vout)
    );

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_ADD, OP_SUB, OP_BEQ: begin
                w_res = w_sum;
                w_c   = w_cout;
                w_v   = w_vout;
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_vout};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_cout};
            default: w_res = '0;
        endcase
    end

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The final multiply step commits its own partial sum straight into the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            if (bus.op == OP_MUL) begin
                r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                r_mplier <= bus.b;
                r_acc    <= '0;
                r_cnt    <= CW'(WIDTH);
            end else begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_carry  <= w_c;
                r_ovf    <= w_v;
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_mul_last) begin
                r_result <= w_acc_nxt[WIDTH-1:0];
                r_zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
                r_carry  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_ovf    <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) & ~rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_seq_alu_mul.sv
// Directed vector bench for seq_alu_mul at WIDTH=32 and WIDTH=8.
module tb_seq_alu_mul;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_mul_if #(.WIDTH(32)) bus32 ();
    seq_alu_mul_if #(.WIDTH(8))  bus8 ();

    seq_alu_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_alu_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    // lat = cycles from accept until out_valid is seen
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res,
                         output logic z, output logic c, output logic v, output int busy);
        int w = 0;
        while (!bus32.in_ready && w < 200) begin @(posedge clk); #1; w++; end
        bus32.op = op; bus32.a = a; bus32.b = b; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 1; busy = 0;
        while (!bus32.out_valid && lat < 200) begin
            if (bus32.in_ready) busy++;
            @(posedge clk); #1; lat++;
        end
        res = bus32.result; z = bus32.zero; c = bus32.carry; v = bus32.overflow;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [7:0] res,
                        output logic z, output logic c, output logic v);
        int w = 0;
        while (!bus8.in_ready && w < 200) begin @(posedge clk); #1; w++; end
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = bus8.result; z = bus8.zero; c = bus8.carry; v = bus8.overflow;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[11];
        int          lat;
        int          busy;
        logic [31:0] res;
        logic [7:0]  res8;
        logic        z, c, v;

        vecs[0]  = '{"add_wrap",  OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 1, 0, 1};
        vecs[1]  = '{"sub_ovf",   OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 1, 1};
        vecs[2]  = '{"beq_eq",    OP_BEQ,  32'h1234,     32'h1234,     32'h0,        1, 1, 0, 1};
        vecs[3]  = '{"slt_neg",   OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 1};
        vecs[4]  = '{"sltu_big",  OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 1};
        vecs[5]  = '{"slt_ovf",   OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h0,        1, 0, 0, 1};
        vecs[6]  = '{"sub_borrow",OP_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 0, 0, 0, 1};
        vecs[7]  = '{"sltu_lt",   OP_SLTU, 32'h5,        32'h7,        32'h1,        0, 0, 0, 1};
        vecs[8]  = '{"or",        OP_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 0, 0, 0, 1};
        vecs[9]  = '{"mul_hi",    OP_MUL,  32'h10000,    32'h10000,    32'h0,        1, 1, 0, 33};
        vecs[10] = '{"mul_small", OP_MUL,  32'd1000,     32'd3000,     32'd3000000,  0, 0, 0, 33};

        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = '0; bus32.b = '0; bus32.op = '0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.op  = '0;

        #1;
        chk("rst_in_ready",  64'(bus32.in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus32.out_valid), 64'h0);
        chk("rst_result",    64'(bus32.result), 64'h0);
        chk("rst_flags",     64'({bus32.zero, bus32.carry, bus32.overflow}), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus32.in_ready), 64'h1);

        for (int i = 0; i < 11; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z, c, v, busy);
            chk({vecs[i].name, "_result"},  64'(res), 64'(vecs[i].res));
            chk({vecs[i].name, "_zcv"},     64'({z, c, v}), 64'({vecs[i].z, vecs[i].c, vecs[i].v}));
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            chk({vecs[i].name, "_busy"},    64'(busy), 64'h0);
        end

        // Backpressure: result held, new request ignored while DONE
        bus32.op = OP_AND; bus32.a = 32'hF0F0F0F0; bus32.b = 32'hFF00FF00; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.op = OP_OR; bus32.a = 32'h1; bus32.b = 32'h2;
        chk("bp_valid", 64'(bus32.out_valid), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", 64'(bus32.result), 64'hF000F000);
            chk("bp_hold_state",  64'({bus32.out_valid, bus32.in_ready}), 64'b10);
        end
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b0;
        chk("bp_release", 64'({bus32.out_valid, bus32.in_ready}), 64'b01);
        @(posedge clk); #1;
        chk("bp_no_accept", 64'({bus32.out_valid, bus32.in_ready}), 64'b01);
        chk("bp_result_kept", 64'(bus32.result), 64'hF000F000);

        run8(OP_MUL, 8'd15, 8'd17, lat, res8, z, c, v);
        chk("w8_mul_result",  64'(res8), 64'd255);
        chk("w8_mul_zcv",     64'({z, c, v}), 64'b000);
        chk("w8_mul_latency", 64'(lat), 64'd9);
        run8(OP_MUL, 8'd16, 8'd16, lat, res8, z, c, v);
        chk("w8_mul_hi",      64'({res8, z, c, v}), 64'({8'h00, 3'b110}));
        run8(OP_ADD, 8'h7F, 8'h01, lat, res8, z, c, v);
        chk("w8_add_ovf",     64'({res8, z, c, v}), 64'({8'h80, 3'b001}));

        // Reset in the tenth cycle of a multiply
        bus32.op = OP_MUL; bus32.a = 32'd3; bus32.b = 32'd5; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midmul_rst_result", 64'(bus32.result), 64'h0);
        chk("midmul_rst_state",  64'({bus32.out_valid, bus32.in_ready, bus32.zero, bus32.carry, bus32.overflow}), 64'h0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("midmul_rst_ready",  64'(bus32.in_ready), 64'h1);
        run32(OP_MUL, 32'd7, 32'd6, lat, res, z, c, v, busy);
        chk("post_rst_mul_result",  64'(res), 64'd42);
        chk("post_rst_mul_latency", 64'(lat), 64'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
